// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM encoding and width defaults for the load/store unit.
// Also provides store-queue pointer sizing used by the queue and the top.
package lsu_pkg;

  localparam int LSU_AW       = 8;
  localparam int LSU_DW       = 8;
  localparam int LSU_SQ_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    RD_DATA = 2'd2
  } lsu_state_e;

  function automatic int sq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus data_memory port.
// slave = the unit's view, master = pipeline + memory side.
interface load_store_unit_if
  import lsu_pkg::*;
#(
  parameter int AW = LSU_AW,
  parameter int DW = LSU_DW
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          sq_empty;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic          mem_memread;
  logic          mem_memwrite;
  logic [DW-1:0] mem_readdata;

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  mem_readdata,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output sq_empty,
    output mem_address,
    output mem_writedata,
    output mem_memread,
    output mem_memwrite
  );

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output mem_readdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  sq_empty,
    input  mem_address,
    input  mem_writedata,
    input  mem_memread,
    input  mem_memwrite
  );

endinterface

// File: rtl/store_queue.sv
// store_queue: circular store FIFO with push/pop, full/empty flags and
// a combinational address lookup returning the youngest matching entry.
module store_queue
  import lsu_pkg::*;
#(
  parameter int AW    = LSU_AW,
  parameter int DW    = LSU_DW,
  parameter int DEPTH = LSU_SQ_DEPTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic          full_o,
  output logic          empty_o,
  input  logic [AW-1:0] lk_addr_i,
  output logic          lk_hit_o,
  output logic [DW-1:0] lk_data_o
);

  localparam int PW = sq_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_ok)  head_d = head_q + PW'(1);
    if (push_ok) tail_d = tail_q + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_ok) begin
        addr_q[tail_q] <= push_addr_i;
        data_q[tail_q] <= push_data_i;
      end
    end
  end

  // Walk oldest to youngest; a later match overwrites, so youngest wins.
  always_comb begin
    lk_hit_o  = 1'b0;
    lk_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) &&
          (addr_q[head_q + PW'(i)] == lk_addr_i)) begin
        lk_hit_o  = 1'b1;
        lk_data_o = data_q[head_q + PW'(i)];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: load/store front end to data_memory with a posted
// store queue, store-to-load forwarding and a 3-state load FSM.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW       = LSU_AW,
  parameter int DW       = LSU_DW,
  parameter int SQ_DEPTH = LSU_SQ_DEPTH
) (
  input  logic             CLK,
  input  logic             RESET_N,
  load_store_unit_if.slave bus
);

  lsu_state_e    state_q, state_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_writedata_q, mem_writedata_d;
  logic          mem_memread_q, mem_memread_d;
  logic          mem_memwrite_q, mem_memwrite_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic          sq_full;
  logic          sq_mt;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          lk_hit;
  logic [DW-1:0] lk_data;

  logic          ready;
  logic          acc;
  logic          st_acc;
  logic          ld_acc;
  logic          drain;

  assign ready  = RESET_N & (state_q == IDLE) & ~sq_full;
  assign acc    = bus.req_valid & ready;
  assign st_acc = acc & bus.req_we;
  assign ld_acc = acc & ~bus.req_we;

  // Loads accepted this edge take the memory port ahead of a drain.
  assign drain  = (state_q == IDLE) & ~sq_mt & ~ld_acc;

  store_queue #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (SQ_DEPTH)
  ) u_sq (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .push_i      (st_acc),
    .push_addr_i (bus.req_addr),
    .push_data_i (bus.req_wdata),
    .pop_i       (drain),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .full_o      (sq_full),
    .empty_o     (sq_mt),
    .lk_addr_i   (bus.req_addr),
    .lk_hit_o    (lk_hit),
    .lk_data_o   (lk_data)
  );

  always_comb begin
    state_d         = state_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    mem_memread_d   = 1'b0;
    mem_memwrite_d  = 1'b0;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          ld_acc & lk_hit: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = lk_data;
          end
          ld_acc & ~lk_hit: begin
            mem_address_d = bus.req_addr;
            mem_memread_d = 1'b1;
            state_d       = RD;
          end
          drain: begin
            mem_memwrite_d  = 1'b1;
            mem_address_d   = head_addr;
            mem_writedata_d = head_data;
          end
          default: ;
        endcase
      end
      RD: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus.mem_readdata;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= IDLE;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      mem_memread_q   <= 1'b0;
      mem_memwrite_q  <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      mem_memread_q   <= mem_memread_d;
      mem_memwrite_q  <= mem_memwrite_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
    end
  end

  assign bus.req_ready     = ready;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;
  assign bus.mem_memread   = mem_memread_q;
  assign bus.mem_memwrite  = mem_memwrite_q;
  // A write issued last edge is still landing in memory.
  assign bus.sq_empty      = sq_mt & ~mem_memwrite_q;

endmodule
